mac_accum_unit: RTL and testbench

- Upstream feeder of the final-data output register in the 10x10 8-bit datapath.
- Accepts a stream of N_TERMS unsigned operand pairs over a valid/ready handshake and multiplies each pair in a registered pipeline stage.
- Accumulates the products with saturation and presents the (2*DATA_WIDTH+1)-bit sum with a one-cycle out_valid pulse.
- out_valid drives the output register's enable; result drives its input data.

---
 rtl/mac_accum_unit_if.sv | 25 ++
 rtl/mac_accum_unit.sv | 118 +++++++++++
 tb/tb_mac_accum_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mac_accum_unit_if.sv
// Operand/result bundle for mac_accum_unit: operand-pair handshake in,
// saturated dot-product result out.
interface mac_accum_unit_if #(
   parameter int DATA_WIDTH = 8
);
   logic                      start;
   logic                      in_valid;
   logic [DATA_WIDTH-1:0]     a_in;
   logic [DATA_WIDTH-1:0]     b_in;
   logic                      in_ready;
   logic [2*DATA_WIDTH:0]     result;
   logic                      out_valid;
   logic                      saturated;
   logic                      busy;

   modport master (
      output start, in_valid, a_in, b_in,
      input  in_ready, result, out_valid, saturated, busy
   );

   modport slave (
      input  start, in_valid, a_in, b_in,
      output in_ready, result, out_valid, saturated, busy
   );
endinterface

// File: rtl/mac_accum_unit.sv
// Multiply-accumulate of N_TERMS unsigned operand pairs with a registered
// product stage and a saturating (2*DATA_WIDTH+1)-bit result.
module mac_accum_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int N_TERMS    = 10,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   mac_accum_unit_if.slave   bus
);
   localparam int PROD_W = 2*DATA_WIDTH;
   localparam int RES_W  = 2*DATA_WIDTH + 1;
   localparam int ACC_W  = 2*DATA_WIDTH + CNT_W;
   localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'({RES_W{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PROD_W-1:0]  prod_q, prod_d;
   logic               prod_valid_q, prod_valid_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               sticky_q, sticky_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               result_sat_q, result_sat_d;

   logic               in_ready;
   logic               transfer;
   logic [ACC_W-1:0]   acc_sum;
   logic               over;

   assign in_ready = (state_q == ST_ACCUM);
   assign transfer = bus.in_valid && in_ready;
   assign acc_sum  = acc_q + (prod_valid_q ? ACC_W'(prod_q) : '0);
   assign over     = (acc_sum > ACC_MAX);

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      prod_d       = prod_q;
      prod_valid_d = 1'b0;
      acc_d        = acc_q;
      sticky_d     = sticky_q;
      result_d     = result_q;
      result_sat_d = result_sat_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d  = ST_ACCUM;
               cnt_d    = '0;
               acc_d    = '0;
               sticky_d = 1'b0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            acc_d    = acc_sum;
            sticky_d = sticky_q | over;
            if (transfer) begin
               prod_d       = PROD_W'(bus.a_in) * PROD_W'(bus.b_in);
               prod_valid_d = 1'b1;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N_TERMS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The last product lands here; result clips at the all-ones value.
            acc_d        = acc_sum;
            sticky_d     = sticky_q | over;
            result_d     = over ? RES_W'(ACC_MAX) : acc_sum[RES_W-1:0];
            result_sat_d = sticky_q | over;
            state_d      = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         prod_q       <= '0;
         prod_valid_q <= 1'b0;
         acc_q        <= '0;
         sticky_q     <= 1'b0;
         result_q     <= '0;
         result_sat_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prod_q       <= prod_d;
         prod_valid_q <= prod_valid_d;
         acc_q        <= acc_d;
         sticky_q     <= sticky_d;
         result_q     <= result_d;
         result_sat_q <= result_sat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.saturated = result_sat_q;

endmodule

// File: tb/tb_mac_accum_unit.sv
// Directed table-driven bench for mac_accum_unit: ten-term dot products,
// saturation, input gaps, back-to-back starts and mid-operation reset.
module tb_mac_accum_unit;
   localparam int N = 10;

   typedef struct {
      bit          ramp;       // pair k uses (k+1, k+1)
      logic [7:0]  a;
      logic [7:0]  b;
      logic [9:0]  gaps;       // bit k: one idle cycle before pair k
      bit          start_mid;  // pulse start alongside pair 3
      bit          chained;    // started from the previous DONE cycle
      logic [16:0] exp_result;
      logic        exp_sat;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [16:0] held_result;
   logic        held_sat;
   vec_t vecs[7];

   mac_accum_unit_if #(.DATA_WIDTH(8)) bus ();

   mac_accum_unit #(.DATA_WIDTH(8), .N_TERMS(N), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_start(input bit with_junk);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.in_valid = with_junk;
      bus.a_in     = 8'd99;
      bus.b_in     = 8'd99;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("start_busy", bus.busy, 1);
      check("start_ready", bus.in_ready, 1);
   endtask

   task automatic feed_and_check(input vec_t v, input bit chain_next);
      for (int k = 0; k < N; k++) begin
         if (v.gaps[k]) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            check("gap_ready", bus.in_ready, 1);
         end
         check("accum_ready", bus.in_ready, 1);
         bus.a_in     = v.ramp ? 8'(k + 1) : v.a;
         bus.b_in     = v.ramp ? 8'(k + 1) : v.b;
         bus.in_valid = 1'b1;
         bus.start    = v.start_mid && (k == 3);
         @(negedge clk);
         bus.start    = 1'b0;
      end
      // DRAIN: in_valid stays high with junk data, which must be ignored.
      bus.a_in = 8'd77;
      bus.b_in = 8'd77;
      check("drain_ready", bus.in_ready, 0);
      check("drain_busy", bus.busy, 1);
      check("drain_ovalid", bus.out_valid, 0);
      check("drain_held_result", bus.result, held_result);
      @(negedge clk);
      check("done_ovalid", bus.out_valid, 1);
      check("done_result", bus.result, v.exp_result);
      check("done_sat", bus.saturated, v.exp_sat);
      check("done_busy", bus.busy, 0);
      check("done_ready", bus.in_ready, 0);
      held_result  = v.exp_result;
      held_sat     = v.exp_sat;
      bus.start    = chain_next;
      bus.in_valid = !chain_next;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("after_ovalid", bus.out_valid, 0);
      check("after_busy", bus.busy, chain_next);
      check("after_ready", bus.in_ready, chain_next);
      check("after_result_hold", bus.result, held_result);
      check("after_sat_hold", bus.saturated, held_sat);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      held_result  = '0;
      held_sat     = 1'b0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.a_in     = '0;
      bus.b_in     = '0;

      //            ramp a    b    gaps          mid  chain exp       sat
      vecs[0] = '{1'b1, 8'd0,   8'd0,   10'b0,          1'b0, 1'b0, 17'd385,    1'b0};
      vecs[1] = '{1'b0, 8'd255, 8'd255, 10'b0,          1'b0, 1'b0, 17'h1FFFF,  1'b1};
      vecs[2] = '{1'b0, 8'd255, 8'd128, 10'b0010100100, 1'b1, 1'b0, 17'h1FFFF,  1'b1};
      vecs[3] = '{1'b0, 8'd200, 8'd65,  10'b0,          1'b0, 1'b0, 17'd130000, 1'b0};
      vecs[4] = '{1'b0, 8'd3,   8'd4,   10'b0,          1'b0, 1'b1, 17'd120,    1'b0};
      vecs[5] = '{1'b0, 8'd0,   8'd0,   10'b0,          1'b0, 1'b0, 17'd0,      1'b0};
      vecs[6] = '{1'b0, 8'd1,   8'd2,   10'b0,          1'b0, 1'b0, 17'd20,     1'b0};

      repeat (2) @(negedge clk);
      check("rst_result", bus.result, 0);
      check("rst_ovalid", bus.out_valid, 0);
      check("rst_sat", bus.saturated, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b0;

      // in_valid without start in IDLE must not be accepted.
      bus.in_valid = 1'b1;
      bus.a_in     = 8'd50;
      bus.b_in     = 8'd50;
      repeat (3) begin
         @(negedge clk);
         check("idle_ready", bus.in_ready, 0);
         check("idle_busy", bus.busy, 0);
      end
      bus.in_valid = 1'b0;

      for (int i = 0; i < 6; i++) begin
         if (!vecs[i].chained) do_start(i == 0);
         feed_and_check(vecs[i], (i + 1 < 6) && vecs[i + 1].chained);
      end

      // Reset part-way through an operation aborts without out_valid.
      do_start(1'b0);
      for (int k = 0; k < 5; k++) begin
         bus.a_in     = 8'd10;
         bus.b_in     = 8'd10;
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      check("abort_result", bus.result, 0);
      check("abort_ovalid", bus.out_valid, 0);
      check("abort_sat", bus.saturated, 0);
      check("abort_ready", bus.in_ready, 0);
      check("abort_busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("abort_ovalid_hold", bus.out_valid, 0);
      reset       = 1'b0;
      held_result = '0;
      held_sat    = 1'b0;
      do_start(1'b0);
      feed_and_check(vecs[6], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
